// File: rtl/fulladd_r.sv
// Ripple-carry adder built from half-adder pairs, with optional output registers.
// Produces the sum, the carry-out and the two's-complement overflow flag.
module fulladd_r #(
    parameter int WIDTH   = 4,
    parameter bit REG_OUT = 1'b1
) (
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic             cin,
    output logic [WIDTH-1:0] o,
    output logic             cout,
    input  logic             clk,
    input  logic             reset,
    output logic             ovf
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_next;
    logic             cout_next;
    logic             ovf_next;

    // Each cell: first half adder on the operands, second on its sum and the carry-in.
    always_comb begin : ripple
        logic ha1_s;
        logic ha1_c;
        logic ha2_s;
        logic ha2_c;
        carry    = '0;
        sum_next = '0;
        ha1_s    = 1'b0;
        ha1_c    = 1'b0;
        ha2_s    = 1'b0;
        ha2_c    = 1'b0;
        carry[0] = cin;
        for (int k = 0; k < WIDTH; k++) begin
            ha1_s        = i0[k] ^ i1[k];
            ha1_c        = i0[k] & i1[k];
            ha2_s        = ha1_s ^ carry[k];
            ha2_c        = ha1_s & carry[k];
            sum_next[k]  = ha2_s;
            carry[k+1]   = ha1_c | ha2_c;
        end
        cout_next = carry[WIDTH];
        ovf_next  = carry[WIDTH] ^ carry[WIDTH-1];
    end

    generate
        if (REG_OUT) begin : g_reg
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    o    <= '0;
                    cout <= 1'b0;
                    ovf  <= 1'b0;
                end else begin
                    o    <= sum_next;
                    cout <= cout_next;
                    ovf  <= ovf_next;
                end
            end
        end else begin : g_comb
            assign o    = sum_next;
            assign cout = cout_next;
            assign ovf  = ovf_next;
        end
    endgenerate

endmodule

// File: tb/tb_fulladd_r.sv
// Self-checking bench for fulladd_r: registered and combinational instances side by side
// against an arithmetic reference (integer add plus signed range check).
`timescale 1ns/1ps
module tb_fulladd_r;

    localparam int W = 4;

    logic         clk   = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] i0    = '0;
    logic [W-1:0] i1    = '0;
    logic         cin   = 1'b0;

    logic [W-1:0] o_reg;
    logic         cout_reg;
    logic         ovf_reg;
    logic [W-1:0] o_comb;
    logic         cout_comb;
    logic         ovf_comb;

    int  checks  = 0;
    int  errors  = 0;
    bit  started = 1'b0;
    logic [W+1:0] exp_reg = '0;

    fulladd_r #(.WIDTH(W), .REG_OUT(1'b1)) dut_reg (
        .i0(i0), .i1(i1), .cin(cin), .o(o_reg), .cout(cout_reg),
        .clk(clk), .reset(reset), .ovf(ovf_reg)
    );

    fulladd_r #(.WIDTH(W), .REG_OUT(1'b0)) dut_comb (
        .i0(i0), .i1(i1), .cin(cin), .o(o_comb), .cout(cout_comb),
        .clk(clk), .reset(reset), .ovf(ovf_comb)
    );

    always #5 clk = ~clk;

    // Reference result packed as {cout, o, ovf}.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c);
        int u;
        int sa;
        int sb;
        int s;
        logic [W:0] wide;
        logic v;
        u  = int'(a) + int'(b) + int'(c);
        sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
        sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
        s  = sa + sb + int'(c);
        v  = (s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)));
        wide = u[W:0];
        return {wide, v};
    endfunction

    task automatic compare(input string name, input logic [W+1:0] act, input logic [W+1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got cout/o/ovf=%b required %b at %0t", name, act, req, $time);
        end
    endtask

    // Registered instance: async clear, otherwise capture the reference each rising edge.
    always @(posedge clk or posedge reset) begin
        if (reset) exp_reg = '0;
        else       exp_reg = model(i0, i1, cin);
    end

    always @(negedge clk) begin
        if (started) begin
            compare("reg_track", {cout_reg, o_reg, ovf_reg}, exp_reg);
            compare("comb_track", {cout_comb, o_comb, ovf_comb}, model(i0, i1, cin));
        end
    end

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        @(negedge clk);
        #1;
        i0  = a;
        i1  = b;
        cin = c;
    endtask

    task automatic checkOutput(input string name, input logic [W+1:0] req);
        @(posedge clk);
        #2;
        compare({name, "_reg"}, {cout_reg, o_reg, ovf_reg}, req);
        compare({name, "_comb"}, {cout_comb, o_comb, ovf_comb}, req);
    endtask

    initial begin
        reset   = 1'b1;
        i0      = 4'b1111;
        i1      = 4'b1111;
        cin     = 1'b1;
        started = 1'b1;
        #7;
        compare("reset_hold_reg", {cout_reg, o_reg, ovf_reg}, 6'b0_0000_0);
        compare("reset_comb", {cout_comb, o_comb, ovf_comb}, 6'b1_1111_0);
        #5.5;
        reset = 1'b0;

        applyStimulus(4'b0000, 4'b0000, 1'b0); checkOutput("zero_c0",   6'b0_0000_0);
        applyStimulus(4'b0000, 4'b0000, 1'b1); checkOutput("zero_c1",   6'b0_0001_0);
        applyStimulus(4'b0001, 4'b0001, 1'b0); checkOutput("one_c0",    6'b0_0010_0);
        applyStimulus(4'b0001, 4'b0001, 1'b1); checkOutput("one_c1",    6'b0_0011_0);
        applyStimulus(4'b0010, 4'b0010, 1'b0); checkOutput("two_c0",    6'b0_0100_0);
        applyStimulus(4'b0010, 4'b0010, 1'b1); checkOutput("two_c1",    6'b0_0101_0);
        applyStimulus(4'b1010, 4'b1011, 1'b0); checkOutput("neg_ovf_c0", 6'b1_0101_1);
        applyStimulus(4'b1010, 4'b1011, 1'b1); checkOutput("neg_ovf_c1", 6'b1_0110_1);
        applyStimulus(4'b1110, 4'b1111, 1'b0); checkOutput("neg_c0",    6'b1_1101_0);
        applyStimulus(4'b1110, 4'b1111, 1'b1); checkOutput("neg_c1",    6'b1_1110_0);
        applyStimulus(4'b1111, 4'b1111, 1'b1); checkOutput("wrap_max",  6'b1_1111_0);
        applyStimulus(4'b1111, 4'b0000, 1'b1); checkOutput("wrap_zero", 6'b1_0000_0);
        applyStimulus(4'b0111, 4'b0000, 1'b1); checkOutput("pos_ovf",   6'b0_1000_1);

        // Mid-operation reset must clear immediately and block the following edge.
        applyStimulus(4'b1001, 4'b1001, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #3;
        reset = 1'b1;
        #1;
        compare("async_reset", {cout_reg, o_reg, ovf_reg}, 6'b0_0000_0);
        @(posedge clk);
        #1;
        compare("reset_blocks_edge", {cout_reg, o_reg, ovf_reg}, 6'b0_0000_0);
        @(negedge clk);
        #3;
        reset = 1'b0;
        checkOutput("reload", 6'b1_0010_1);

        for (int n = 0; n < 512; n++) begin
            logic [8:0] v;
            v = n[8:0];
            applyStimulus(v[8:5], v[4:1], v[0]);
        end

        for (int n = 0; n < 300; n++) begin
            applyStimulus(W'($urandom_range(15)), W'($urandom_range(15)), 1'($urandom_range(1)));
        end

        @(negedge clk);
        @(negedge clk);
        #1;
        started = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/fulladd_r.md
FULLADD_R -- requirements
Module: fulladd_r

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand and sum width in bits (legal range 1..32).
REQ-002 The block SHALL have parameter REG_OUT, default 1: 1 = registered outputs, 0 = purely combinational outputs.
REQ-003 The block SHALL have port clk  input  1  single system clock, rising-edge active.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port i0  input  WIDTH  addend A, unsigned.
REQ-006 The block SHALL have port i1  input  WIDTH  addend B, unsigned.
REQ-007 The block SHALL have port cin  input  1  carry-in.
REQ-008 The block SHALL have port o  output  WIDTH  sum bits.
REQ-009 The block SHALL have port cout  output  1  carry-out of the MSB stage.
REQ-010 The block SHALL have port ovf  output  1  two's-complement overflow flag.
REQ-011 Port order SHALL be i0, i1, cin, o, cout, clk, reset, ovf, so that a positional 5-port connection (i0, i1, cin, o, cout) binds correctly.

Function
REQ-012 The adder SHALL be a ripple-carry chain of WIDTH full-adder cells.
- Cell k takes i0[k], i1[k] and carry c[k]; c[0] = cin.
- Each cell is built from two half adders and an OR gate.
- s[k] = i0[k] ^ i1[k] ^ c[k].
- c[k+1] = (i0[k] & i1[k]) | (c[k] & (i0[k] ^ i1[k])).
REQ-013 The arithmetic result {cout, o} SHALL equal i0 + i1 + cin exactly, modulo 2^(WIDTH+1); no saturation.
REQ-014 ovf SHALL equal c[WIDTH] ^ c[WIDTH-1] (for WIDTH=1: c[1] ^ cin).
REQ-015 With REG_OUT=1, the block SHALL capture o, cout and ovf on each rising clk edge.
- Latency is exactly 1 cycle from an input change to the outputs.
- There is no enable; the block samples every cycle.
REQ-016 With REG_OUT=0, o, cout and ovf SHALL follow the inputs combinationally, with zero latency, and clk and reset SHALL have no effect.
REQ-017 Boundary values SHALL wrap:
- All-ones + all-ones + 1 gives o = all-ones, cout = 1.
- All-ones + 0 + 1 gives o = 0, cout = 1.
REQ-018 The block SHALL contain no X-propagating logic; every output is fully defined whenever the inputs are defined.

Reset
REQ-019 While reset = 1 and REG_OUT = 1, o, cout and ovf SHALL be 0.
- Reset takes effect immediately, without waiting for a clk edge.
REQ-020 Reset asserted mid-operation SHALL override the next clk edge.
- After reset deasserts, the first rising clk edge SHALL load the current sum.
REQ-021 Reset SHALL have no effect on the combinational ripple chain itself.

Verification
REQ-022 Bench SHALL apply i0=0000, i1=0000, cin=0, then cin=1 -> o=0000/cout=0, then o=0001/cout=0.
REQ-023 Bench SHALL apply i0=0001, i1=0001, cin=0/1 -> o=0010/0011, cout=0; and i0=0010, i1=0010, cin=0/1 -> o=0100/0101, cout=0.
REQ-024 Bench SHALL apply i0=1010, i1=1011, cin=0 -> o=0101, cout=1, ovf=1; with cin=1 -> o=0110, cout=1.
REQ-025 Bench SHALL apply i0=1110, i1=1111, cin=0 -> o=1101, cout=1, ovf=0; with cin=1 -> o=1110, cout=1.
REQ-026 Bench SHALL hold reset=1 for the first 12.5 ns with a 10 ns clk period.
- During reset, outputs SHALL be 0 regardless of the inputs.
- After release, each result SHALL appear one rising edge after its input changes (REG_OUT=1).
REQ-027 Bench SHALL run an exhaustive sweep of all 512 {i0, i1, cin} combinations at WIDTH=4, for both REG_OUT values, comparing {cout, o} against i0+i1+cin and ovf against the signed-overflow reference.
